// File: rtl/secuenciador_ciclo_if.sv
// Bus between the payment controller and the washer cycle sequencer.
// Handshake: VERIFICACION is a single-cycle request with no ready/ack. It is
// accepted only on an edge where the sequencer is in REPOSO with INSUFCIENTE=0
// and at least one selection high. In any other case it is dropped, and the
// controller learns of acceptance from OCUPADO/FASE.
interface secuenciador_ciclo_if;
    // Payment controller -> sequencer
    logic       VERIFICACION;
    logic       INSUFCIENTE;
    logic       LAVADO;
    logic       LAVADO_PESADO;
    logic       SECADO;
    logic       PAUSA;
    // Sequencer -> actuators / status
    logic       LLENADO_V;
    logic       MOTOR_AGIT;
    logic       BOMBA;
    logic       MOTOR_CENTRI;
    logic       SECADORA;
    logic       OCUPADO;
    logic       TERMINADO;
    logic [2:0] FASE;

    modport master (
        output VERIFICACION, INSUFCIENTE, LAVADO, LAVADO_PESADO, SECADO, PAUSA,
        input  LLENADO_V, MOTOR_AGIT, BOMBA, MOTOR_CENTRI, SECADORA,
        input  OCUPADO, TERMINADO, FASE
    );

    modport slave (
        input  VERIFICACION, INSUFCIENTE, LAVADO, LAVADO_PESADO, SECADO, PAUSA,
        output LLENADO_V, MOTOR_AGIT, BOMBA, MOTOR_CENTRI, SECADORA,
        output OCUPADO, TERMINADO, FASE
    );
endinterface

// File: rtl/secuenciador_ciclo.sv
// Washer/dryer cycle sequencer. It latches the service selection at start.
// It then walks the fill/agitate/drain/spin/dry phases, each timed by a
// 9-bit down-counter. PAUSA freezes the phase and blanks the actuators.
// FASE is the raw state register and doubles as the FSM debug view.
module secuenciador_ciclo #(
    parameter int T_LLENADO = 2,
    parameter int T_AGIT    = 4,
    parameter int T_DRENADO = 2,
    parameter int T_CENTRI  = 3,
    parameter int T_SECADO  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    secuenciador_ciclo_if.slave   bus
);

    typedef enum logic [2:0] {
        REPOSO       = 3'd0,
        LLENADO      = 3'd1,
        AGITACION    = 3'd2,
        DRENADO      = 3'd3,
        CENTRIFUGADO = 3'd4,
        SECADO_F     = 3'd5,
        FIN          = 3'd6
    } estado_t;

    // Counter reload values: a phase of N cycles starts at N-1 and exits at 0.
    localparam logic [8:0] C_LLENADO  = 9'(T_LLENADO - 1);
    localparam logic [8:0] C_AGIT     = 9'(T_AGIT - 1);
    localparam logic [8:0] C_AGIT_P   = 9'(2 * T_AGIT - 1);
    localparam logic [8:0] C_DRENADO  = 9'(T_DRENADO - 1);
    localparam logic [8:0] C_CENTRI   = 9'(T_CENTRI - 1);
    localparam logic [8:0] C_SECADO   = 9'(T_SECADO - 1);

    estado_t    r_estado;
    logic [8:0] r_cnt;
    logic       r_sel_pesado;
    logic       r_sel_secado;
    logic       r_llenado_v;
    logic       r_motor_agit;
    logic       r_bomba;
    logic       r_motor_centri;
    logic       r_secadora;
    logic       r_ocupado;
    logic       r_terminado;

    estado_t    w_estado_nx;
    logic [8:0] w_cnt_nx;
    logic       w_sel_pesado_nx;
    logic       w_sel_secado_nx;
    logic       w_arranque;
    logic       w_pausado;

    function automatic logic es_activo(input estado_t e);
        return (e == LLENADO) || (e == AGITACION) || (e == DRENADO) ||
               (e == CENTRIFUGADO) || (e == SECADO_F);
    endfunction

    // Next-state, counter and selection-latch logic.
    always_comb begin
        w_estado_nx     = r_estado;
        w_cnt_nx        = r_cnt;
        w_sel_pesado_nx = r_sel_pesado;
        w_sel_secado_nx = r_sel_secado;
        w_arranque      = bus.VERIFICACION && !bus.INSUFCIENTE &&
                          (bus.LAVADO || bus.LAVADO_PESADO || bus.SECADO);
        w_pausado       = bus.PAUSA && es_activo(r_estado);
        case (r_estado)
            REPOSO: begin
                if (w_arranque) begin
                    w_sel_pesado_nx = bus.LAVADO_PESADO;
                    w_sel_secado_nx = bus.SECADO;
                    if (bus.LAVADO || bus.LAVADO_PESADO) begin
                        w_estado_nx = LLENADO;
                        w_cnt_nx    = C_LLENADO;
                    end else begin
                        w_estado_nx = SECADO_F;
                        w_cnt_nx    = C_SECADO;
                    end
                end
            end
            LLENADO, AGITACION, DRENADO, CENTRIFUGADO, SECADO_F: begin
                if (!bus.PAUSA) begin
                    if (r_cnt != 9'd0) begin
                        w_cnt_nx = r_cnt - 9'd1;
                    end else begin
                        case (r_estado)
                            LLENADO: begin
                                w_estado_nx = AGITACION;
                                w_cnt_nx    = r_sel_pesado ? C_AGIT_P : C_AGIT;
                            end
                            AGITACION: begin
                                w_estado_nx = DRENADO;
                                w_cnt_nx    = C_DRENADO;
                            end
                            DRENADO: begin
                                w_estado_nx = CENTRIFUGADO;
                                w_cnt_nx    = C_CENTRI;
                            end
                            CENTRIFUGADO: begin
                                w_estado_nx = r_sel_secado ? SECADO_F : FIN;
                                w_cnt_nx    = r_sel_secado ? C_SECADO : 9'd0;
                            end
                            default: begin
                                w_estado_nx = FIN;
                                w_cnt_nx    = 9'd0;
                            end
                        endcase
                    end
                end
            end
            FIN: begin
                w_estado_nx     = REPOSO;
                w_cnt_nx        = 9'd0;
                w_sel_pesado_nx = 1'b0;
                w_sel_secado_nx = 1'b0;
            end
            default: begin
                w_estado_nx     = REPOSO;
                w_cnt_nx        = 9'd0;
                w_sel_pesado_nx = 1'b0;
                w_sel_secado_nx = 1'b0;
            end
        endcase
    end

    // State register plus registered outputs. The outputs are decoded from
    // the next state so they line up with the phase they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado       <= REPOSO;
            r_cnt          <= 9'd0;
            r_sel_pesado   <= 1'b0;
            r_sel_secado   <= 1'b0;
            r_llenado_v    <= 1'b0;
            r_motor_agit   <= 1'b0;
            r_bomba        <= 1'b0;
            r_motor_centri <= 1'b0;
            r_secadora     <= 1'b0;
            r_ocupado      <= 1'b0;
            r_terminado    <= 1'b0;
        end else begin
            r_estado       <= w_estado_nx;
            r_cnt          <= w_cnt_nx;
            r_sel_pesado   <= w_sel_pesado_nx;
            r_sel_secado   <= w_sel_secado_nx;
            r_llenado_v    <= (w_estado_nx == LLENADO)      && !w_pausado;
            r_motor_agit   <= (w_estado_nx == AGITACION)    && !w_pausado;
            r_bomba        <= (w_estado_nx == DRENADO)      && !w_pausado;
            r_motor_centri <= (w_estado_nx == CENTRIFUGADO) && !w_pausado;
            r_secadora     <= (w_estado_nx == SECADO_F)     && !w_pausado;
            r_ocupado      <= es_activo(w_estado_nx);
            r_terminado    <= (w_estado_nx == FIN);
        end
    end

    assign bus.LLENADO_V    = r_llenado_v;
    assign bus.MOTOR_AGIT   = r_motor_agit;
    assign bus.BOMBA        = r_bomba;
    assign bus.MOTOR_CENTRI = r_motor_centri;
    assign bus.SECADORA     = r_secadora;
    assign bus.OCUPADO      = r_ocupado;
    assign bus.TERMINADO    = r_terminado;
    assign bus.FASE         = r_estado;

endmodule

// File: doc/secuenciador_ciclo.md
SECUENCIADOR_CICLO -- requirements
Module: secuenciador_ciclo

Interface
REQ-001 Parameters SHALL be: T_LLENADO, default 2, fill-phase duration in cycles; T_AGIT, default 4, normal agitation cycles; T_DRENADO, default 2, drain cycles; T_CENTRI, default 3, spin cycles; T_SECADO, default 5, dryer cycles; all values 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 VERIFICACION  input  1  one-cycle pulse from the payment controller: payment accepted, start service.
REQ-005 INSUFCIENTE  input  1  payment-controller flag: amount insufficient; blocks start.
REQ-006 LAVADO, LAVADO_PESADO, SECADO  input  1 each  service selection levels from the payment controller, sampled only at start.
REQ-007 PAUSA  input  1  level; door open/operator pause; freezes the cycle.
REQ-008 LLENADO_V, MOTOR_AGIT, BOMBA, MOTOR_CENTRI, SECADORA  output  1 each  actuator enables, registered.
REQ-009 OCUPADO  output  1  high from first phase until return to REPOSO.
REQ-010 TERMINADO  output  1  one-cycle completion pulse.
REQ-011 FASE  output  3  current state code: REPOSO=0, LLENADO=1, AGITACION=2, DRENADO=3, CENTRIFUGADO=4, SECADO_F=5, FIN=6.

Function
REQ-012 States SHALL be REPOSO, LLENADO, AGITACION, DRENADO, CENTRIFUGADO, SECADO_F, FIN; one-hot or binary encoding is free, FASE uses REQ-011 codes.
REQ-013 Start: in REPOSO, on an edge with VERIFICACION=1, INSUFCIENTE=0 and at least one of LAVADO/LAVADO_PESADO/SECADO=1, the block SHALL latch the selection and enter the first phase on that edge.
REQ-014 Start with INSUFCIENTE=1 or no selection SHALL be ignored (remain REPOSO, no outputs).
REQ-015 Wash present (LAVADO or LAVADO_PESADO): sequence LLENADO -> AGITACION -> DRENADO -> CENTRIFUGADO, then SECADO_F if SECADO latched, then FIN.
REQ-016 LAVADO_PESADO SHALL take priority over LAVADO; heavy wash agitation lasts 2*T_AGIT cycles.
REQ-017 SECADO only: sequence SECADO_F -> FIN.
REQ-018 Each phase SHALL last exactly its parameter in unpaused cycles: 9-bit down-counter loaded with duration-1 on phase entry, phase exits on the edge where counter=0 and PAUSA=0.
REQ-019 Actuator mapping, one-to-one: LLENADO->LLENADO_V, AGITACION->MOTOR_AGIT, DRENADO->BOMBA, CENTRIFUGADO->MOTOR_CENTRI, SECADO_F->SECADORA; all others 0.
REQ-020 PAUSA=1 in any active phase SHALL freeze counter and state, force all actuator outputs 0, keep OCUPADO=1 and FASE unchanged; on release, the phase resumes with the remaining count.
REQ-021 FIN SHALL last one cycle with TERMINADO=1, OCUPADO=0, then return to REPOSO; PAUSA is ignored in FIN and REPOSO.
REQ-022 VERIFICACION while not in REPOSO SHALL be ignored; selection inputs changing mid-cycle SHALL have no effect.
REQ-023 Only one actuator output SHALL be high in any cycle.

Reset
REQ-024 rst=0 SHALL immediately, without waiting for a clock edge, force REPOSO, counter 0, latched selection 0, and all outputs 0 (FASE=0).
REQ-025 Reset asserted mid-cycle SHALL abort the service with no TERMINADO pulse; operation resumes on the first edge after rst=1.

Verification (default parameters; start edge = k)
REQ-026 LAVADO=1, VERIFICACION pulse -> LLENADO_V cycles k+1..k+2, MOTOR_AGIT k+3..k+6, BOMBA k+7..k+8, MOTOR_CENTRI k+9..k+11, TERMINADO at k+12 only.
REQ-027 LAVADO=1 and LAVADO_PESADO=1 -> MOTOR_AGIT for 8 cycles, TERMINADO at k+16; LAVADO+SECADO -> SECADORA k+12..k+16, TERMINADO at k+17.
REQ-028 SECADO only -> SECADORA k+1..k+5, TERMINADO at k+6; INSUFCIENTE=1 at start -> FASE stays 0, no outputs for 20 cycles.
REQ-029 LAVADO, PAUSA=1 for 3 cycles during AGITACION -> MOTOR_AGIT=0 and FASE=2 while paused, TERMINADO delayed to k+15.
REQ-030 rst=0 asserted between clock edges during CENTRIFUGADO -> all outputs 0 before the next edge, no TERMINADO; a subsequent start runs the full REQ-026 sequence.
REQ-031 Second VERIFICACION during DRENADO -> timing per REQ-026 unchanged, exactly one TERMINADO.
